// File: rtl/jtframe_romarb_if.sv
// SDRAM read-port bundle between the ROM arbiter (master) and the SDRAM controller (slave).
interface jtframe_romarb_if;
  logic        sdram_req;
  logic        sdram_ack;
  logic [21:0] sdram_addr;
  logic        data_dst;
  logic        data_rdy;
  logic [15:0] data_read;

  modport master (
    output sdram_req, sdram_addr,
    input  sdram_ack, data_dst, data_rdy, data_read
  );

  modport slave (
    input  sdram_req, sdram_addr,
    output sdram_ack, data_dst, data_rdy, data_read
  );
endinterface

// File: rtl/jtframe_romarb.sv
// jtframe_romarb: N-slot SDRAM ROM read arbiter with a one-word cache per slot.
// Define JTFRAME_ROMARB_RR_EN for round-robin arbitration (default: fixed priority, slot 0 first).
module jtframe_romarb #(
  parameter int                  SLOTS   = 4,
  parameter int                  AW      = 18,
  parameter int                  DW      = 8,
  parameter logic [SLOTS*22-1:0] OFFSETS = '0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  jtframe_romarb_if.master    sdram
);
  // state   | meaning
  // ST_IDLE | no fetch in flight; arbitrate among pending misses
  // ST_REQ  | sdram_req/sdram_addr held until the controller acks
  // ST_WAIT | request accepted; waiting for data_dst / data_rdy
  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  state_t           state, state_nxt;
  logic             req_q, req_nxt;
  logic [21:0]      addr_q, addr_nxt;
  logic [IW-1:0]    win, win_nxt;
  logic [AW-1:0]    tag_cap, tag_cap_nxt;
  logic             fill;

  logic [SLOTS-1:0] valid;
  logic [AW-1:0]    tag   [SLOTS];
  logic [15:0]      cache [SLOTS];
  logic [AW-1:0]    wa    [SLOTS];
  logic [SLOTS-1:0] pending;
  logic             found;
  logic [IW-1:0]    sel;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [AW-1:0] a;
    assign a = slot_addr[AW*i +: AW];
    if (DW == 8) begin : g_byte
      assign wa[i] = a >> 1;
      assign slot_dout[DW*i +: DW] = a[0] ? cache[i][15:8] : cache[i][7:0];
    end else begin : g_word
      assign wa[i] = a;
      assign slot_dout[DW*i +: DW] = cache[i];
    end
    // Hit is purely combinational so an address change drops ok in the same cycle.
    assign slot_ok[i] = slot_cs[i] & valid[i] & (tag[i] == wa[i]) & ~downloading;
    assign pending[i] = slot_cs[i] & ~slot_ok[i];
  end

`ifdef JTFRAME_ROMARB_RR_EN
  logic [IW-1:0] rr_ptr;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= SLOTS; k++) begin
      if (!found && pending[(int'(rr_ptr) + k) % SLOTS]) begin
        found = 1'b1;
        sel   = IW'((int'(rr_ptr) + k) % SLOTS);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      rr_ptr <= '0;
    else if (state == ST_IDLE && state_nxt == ST_REQ)
      rr_ptr <= sel;
  end
`else
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = SLOTS - 1; k >= 0; k--) begin
      if (pending[k]) begin
        found = 1'b1;
        sel   = IW'(k);
      end
    end
  end
`endif

  always_comb begin
    state_nxt   = state;
    req_nxt     = req_q;
    addr_nxt    = addr_q;
    win_nxt     = win;
    tag_cap_nxt = tag_cap;
    fill        = 1'b0;
    if (downloading) begin
      state_nxt = ST_IDLE;
      req_nxt   = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            win_nxt     = sel;
            tag_cap_nxt = wa[sel];
            req_nxt     = 1'b1;
            addr_nxt    = OFFSETS[22*sel +: 22] + 22'(wa[sel]);
            state_nxt   = ST_REQ;
          end
        end
        ST_REQ: begin
          if (sdram.sdram_ack) begin
            req_nxt   = 1'b0;
            state_nxt = ST_WAIT;
          end
        end
        ST_WAIT: begin
          fill = sdram.data_dst;
          if (sdram.data_rdy) state_nxt = ST_IDLE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      win     <= '0;
      tag_cap <= '0;
    end else begin
      state   <= state_nxt;
      req_q   <= req_nxt;
      addr_q  <= addr_nxt;
      win     <= win_nxt;
      tag_cap <= tag_cap_nxt;
    end
  end

  // The fill uses the tag captured at grant time, so a requester that moved on re-misses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid <= '0;
      for (int i = 0; i < SLOTS; i++) begin
        tag[i]   <= '0;
        cache[i] <= '0;
      end
    end else if (downloading) begin
      valid <= '0;
    end else if (fill) begin
      valid[win] <= 1'b1;
      tag[win]   <= tag_cap;
      cache[win] <= sdram.data_read;
    end
  end

  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_addr = addr_q;
endmodule

// File: tb/tb_jtframe_romarb.sv
// Self-checking bench for jtframe_romarb (default build, fixed priority).
module tb_jtframe_romarb;
  localparam int SLOTS = 4;
  localparam int AW    = 18;
  localparam int DW    = 8;
  localparam logic [SLOTS*22-1:0] OFFS = {22'h020000, 22'h3FFFFF, 22'h010000, 22'h050000};

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                downloading = 1'b0;
  logic [SLOTS-1:0]    slot_cs = '0;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;

  jtframe_romarb_if bus();

  jtframe_romarb #(.SLOTS(SLOTS), .AW(AW), .DW(DW), .OFFSETS(OFFS)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .downloading(downloading),
    .slot_cs    (slot_cs),
    .slot_addr  (slot_addr),
    .slot_ok    (slot_ok),
    .slot_dout  (slot_dout),
    .sdram      (bus)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  logic [21:0] exp_q[$];

  typedef struct {
    int            slot;
    logic [AW-1:0] addr;
    logic [15:0]   data;
    int            ack_dly;
    logic [21:0]   exp_sa;
    logic [7:0]    exp_dout;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a);
    slot_addr[AW*i +: AW] = a;
  endtask

  function automatic logic [7:0] dout_of(input int i);
    return slot_dout[DW*i +: DW];
  endfunction

  task automatic wait_req(output bit got);
    int n;
    n = 0;
    while (bus.sdram_req !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    got = (bus.sdram_req === 1'b1);
    if (!got) begin
      n_total++;
      $display("FAIL req_timeout: sdram_req low for %0d cycles, expected a request", n);
    end
  endtask

  task automatic sb_pop(input string name);
    if (exp_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: request to 0x%0h with nothing expected", name, bus.sdram_addr);
    end else begin
      check(name, 32'(bus.sdram_addr), 32'(exp_q.pop_front()));
    end
  endtask

  // Wait for a request, compare it against the scoreboard, then ack and return data.
  task automatic serve(input string name, input logic [15:0] data, input int ack_dly);
    bit          got;
    bit          stable;
    logic [21:0] a0;
    wait_req(got);
    if (got) begin
      sb_pop({name, "_addr"});
      a0 = bus.sdram_addr;
      stable = 1'b1;
      repeat (ack_dly) begin
        @(negedge clk);
        if (bus.sdram_req !== 1'b1 || bus.sdram_addr !== a0) stable = 1'b0;
      end
      if (ack_dly > 0) check({name, "_hold"}, 32'(stable), 32'd1);
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0;
      check({name, "_req_drop"}, 32'(bus.sdram_req), 32'd0);
      bus.data_read = data;
      bus.data_dst  = 1'b1;
      bus.data_rdy  = 1'b1;
      @(negedge clk);
      bus.data_dst  = 1'b0;
      bus.data_rdy  = 1'b0;
    end
  endtask

  initial begin
    bit got;
    bit ok_stable;
    bus.sdram_ack = 1'b0;
    bus.data_dst  = 1'b0;
    bus.data_rdy  = 1'b0;
    bus.data_read = '0;
    vecs[0] = '{1, 18'h00000, 16'h1234, 0, 22'h010000, 8'h34};
    vecs[1] = '{2, 18'h00004, 16'hBEEF, 1, 22'h000001, 8'hEF};
    vecs[2] = '{3, 18'h3FFFF, 16'hC3D2, 2, 22'h03FFFF, 8'hC3};
    vecs[3] = '{0, 18'h00101, 16'h7788, 0, 22'h050080, 8'h77};
    vecs[4] = '{2, 18'h00007, 16'h0F1E, 3, 22'h000002, 8'h0F};

    rstn    = 1'b0;
    slot_cs = '1;
    repeat (3) @(negedge clk);
    check("rst_req", 32'(bus.sdram_req), 32'd0);
    check("rst_ok", 32'(slot_ok), 32'd0);
    check("rst_addr", 32'(bus.sdram_addr), 32'd0);
    slot_cs = '0;
    rstn    = 1'b1;
    @(negedge clk);

    set_slot(0, 18'h00010);
    slot_cs = 4'b0001;
    exp_q.push_back(22'h050008);
    serve("s0_fill", 16'hA55A, 0);
    check("s0_ok", 32'(slot_ok), 32'h1);
    check("s0_lo", 32'(dout_of(0)), 32'h5A);
    set_slot(0, 18'h00011);
    #1;
    check("s0_hi_ok", 32'(slot_ok), 32'h1);
    check("s0_hi", 32'(dout_of(0)), 32'hA5);
    ok_stable = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (bus.sdram_req !== 1'b0 || slot_ok !== 4'b0001) ok_stable = 1'b0;
    end
    check("hit_no_req", 32'(ok_stable), 32'd1);

    for (int v = 0; v < 5; v++) begin
      slot_cs = '0;
      set_slot(vecs[v].slot, vecs[v].addr);
      slot_cs[vecs[v].slot] = 1'b1;
      #1;
      check($sformatf("vec%0d_miss", v), 32'(slot_ok), 32'd0);
      exp_q.push_back(vecs[v].exp_sa);
      serve($sformatf("vec%0d", v), vecs[v].data, vecs[v].ack_dly);
      check($sformatf("vec%0d_ok", v), 32'(slot_ok[vecs[v].slot]), 32'd1);
      check($sformatf("vec%0d_dout", v), 32'(dout_of(vecs[v].slot)), 32'(vecs[v].exp_dout));
    end

    slot_cs = '0;
    set_slot(1, 18'h00200);
    set_slot(3, 18'h00402);
    slot_cs = 4'b1010;
    exp_q.push_back(22'h010100);
    exp_q.push_back(22'h020201);
    serve("prio_first", 16'h1111, 0);
    check("prio_ok1", 32'(slot_ok), 32'b0010);
    serve("prio_second", 16'h2233, 0);
    check("prio_ok2", 32'(slot_ok), 32'b1010);
    check("prio_d1", 32'(dout_of(1)), 32'h11);
    check("prio_d3", 32'(dout_of(3)), 32'h33);

    slot_cs = '0;
    set_slot(2, 18'h00010);
    slot_cs = 4'b0100;
    exp_q.push_back(22'h000007);
    serve("stall", 16'h4455, 20);
    check("stall_ok", 32'(slot_ok), 32'b0100);
    check("stall_dout", 32'(dout_of(2)), 32'h55);

    set_slot(0, 18'h00020);
    slot_cs = 4'b1011;
    #1;
    check("abort_pre_ok", 32'(slot_ok), 32'b1010);
    exp_q.push_back(22'h050010);
    wait_req(got);
    if (got) begin
      sb_pop("abort_addr");
      bus.sdram_ack = 1'b1;
      @(negedge clk);
      bus.sdram_ack = 1'b0;
    end
    downloading = 1'b1;
    #1;
    check("dl_ok_comb", 32'(slot_ok), 32'd0);
    @(negedge clk);
    check("dl_req", 32'(bus.sdram_req), 32'd0);
    bus.data_read = 16'hDEAD;
    bus.data_dst  = 1'b1;
    bus.data_rdy  = 1'b1;
    @(negedge clk);
    bus.data_dst  = 1'b0;
    bus.data_rdy  = 1'b0;
    @(negedge clk);
    check("dl_req2", 32'(bus.sdram_req), 32'd0);
    check("dl_ok2", 32'(slot_ok), 32'd0);
    slot_cs     = 4'b0001;
    downloading = 1'b0;
    #1;
    check("dl_invalid", 32'(slot_ok), 32'd0);
    exp_q.push_back(22'h050010);
    serve("refetch", 16'h9A9B, 0);
    check("refetch_ok", 32'(slot_ok), 32'b0001);
    check("refetch_dout", 32'(dout_of(0)), 32'h9B);

    slot_cs = 4'b1000;
    set_slot(3, 18'h00006);
    exp_q.push_back(22'h020003);
    wait_req(got);
    if (got) sb_pop("rst_mid_addr");
    rstn = 1'b0;
    #1;
    check("rst_mid_req", 32'(bus.sdram_req), 32'd0);
    check("rst_mid_sa", 32'(bus.sdram_addr), 32'd0);
    @(negedge clk);
    slot_cs = '0;
    rstn    = 1'b1;
    bus.sdram_ack = 1'b1;
    @(negedge clk);
    bus.sdram_ack = 1'b0;
    bus.data_read = 16'hFFFF;
    bus.data_dst  = 1'b1;
    bus.data_rdy  = 1'b1;
    @(negedge clk);
    bus.data_dst  = 1'b0;
    bus.data_rdy  = 1'b0;
    check("rst_mid_noreq", 32'(bus.sdram_req), 32'd0);
    slot_cs = 4'b1001;
    #1;
    check("rst_mid_ok", 32'(slot_ok), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
